// File: rtl/sfif_pkg.sv
// Shared types for the SFIF transmit arbiter: FSM state codes and TLP header constants.
// The state codes are visible on the sm debug port, so their values are fixed.
package sfif_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_WAIT_CR = 3'd2,
    S_XFER    = 3'd3
  } state_t;

  // fmt/type field of a completion-with-data TLP header
  localparam logic [6:0] FMT_TYPE_CPLD = 7'b100_1010;

endpackage

// File: rtl/sfif_rr_pick.sv
// Cyclic first-set finder: lowest set req index at or after ptr, wrapping. Purely combinational.
// found is low when no request is set; idx is then 0.
module sfif_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  logic [N_REQ-1:0] rot;

  // rotate so that the requester at ptr lands on bit 0
  assign rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/sfif_tx_arb.sv
// Round-robin, whole-TLP arbiter onto the 64b transmit path; grants gated on link credit and tag.
// Grant lands 3 cycles after a request when credit is ready; tx_rdy low stalls the beat with the mux held.
module sfif_tx_arb
  import sfif_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int CR_TIMEOUT = 1024
) (
  input  logic                clk_125,
  input  logic                rstn,
  input  logic                enable,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_np,
  input  logic [4*N_REQ-1:0]  req_pd,
  input  logic [N_REQ-1:0]    req_st,
  input  logic [N_REQ-1:0]    req_end,
  input  logic [N_REQ-1:0]    req_dwen,
  input  logic [64*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_rdy,
  output logic [N_REQ-1:0]    gnt,
  input  logic                credit_available,
  input  logic                tag_available,
  output logic                cp_ph,
  output logic                cp_nph,
  output logic [3:0]          cp_pd,
  input  logic                tx_rdy,
  output logic                tx64_st,
  output logic                tx64_end,
  output logic                tx64_dwen,
  output logic [63:0]         tx64_data,
  output logic                tx_val,
  output logic                skip,
  output logic                proto_err,
  output logic [2:0]          sm
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(CR_TIMEOUT) + 1;

  state_t        state;
  logic [IW-1:0] ptr, cand, pick, cand_next;
  logic [TW-1:0] timer;
  logic          found, cand_np, first;
  logic          pick_np;
  logic [3:0]    pick_pd;
  logic          cand_req, cand_st, cand_end, cand_dwen;
  logic [63:0]   cand_data;
  logic          xfer, go, beat;

  sfif_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick),
    .found (found)
  );

  always_comb begin
    pick_np   = 1'b0;
    pick_pd   = '0;
    cand_req  = 1'b0;
    cand_st   = 1'b0;
    cand_end  = 1'b0;
    cand_dwen = 1'b0;
    cand_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        pick_np = req_np[i];
        pick_pd = req_pd[4*i +: 4];
      end
      if (cand == IW'(i)) begin
        cand_req  = req[i];
        cand_st   = req_st[i];
        cand_end  = req_end[i];
        cand_dwen = req_dwen[i];
        cand_data = req_data[64*i +: 64];
      end
    end
  end

  assign xfer      = (state == S_XFER);
  assign go        = credit_available && (!cand_np || tag_available);
  assign beat      = xfer && tx_rdy;
  assign cand_next = (int'(cand) == N_REQ - 1) ? '0 : cand + IW'(1);

  assign tx_val    = beat;
  assign req_rdy   = beat ? (N_REQ'(1) << cand) : '0;
  assign tx64_st   = xfer && cand_st;
  assign tx64_end  = xfer && cand_end;
  assign tx64_dwen = xfer && cand_dwen;
  assign tx64_data = xfer ? cand_data : '0;
  assign sm        = state;

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cand      <= '0;
      cand_np   <= 1'b0;
      timer     <= '0;
      first     <= 1'b0;
      gnt       <= '0;
      cp_ph     <= 1'b0;
      cp_nph    <= 1'b0;
      cp_pd     <= '0;
      skip      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      skip <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && found) begin
            cand    <= pick;
            cand_np <= pick_np;
            cp_ph   <= !pick_np;
            cp_nph  <= pick_np;
            cp_pd   <= pick_pd;
            state   <= S_SELECT;
          end
        end
        S_SELECT: begin
          timer <= '0;
          if (!enable) begin
            {cp_ph, cp_nph, cp_pd} <= '0;
            state <= S_IDLE;
          end else begin
            state <= S_WAIT_CR;
          end
        end
        S_WAIT_CR: begin
          if (!enable || go || !cand_req || timer == TW'(CR_TIMEOUT - 1)) begin
            {cp_ph, cp_nph, cp_pd} <= '0;
          end
          if (!enable || (!go && !cand_req)) begin
            state <= S_IDLE;
          end else if (go) begin
            gnt   <= N_REQ'(1) << cand;
            first <= 1'b1;
            state <= S_XFER;
          end else if (timer == TW'(CR_TIMEOUT - 1)) begin
            // starved candidate gives way so the others are not blocked behind it
            skip  <= 1'b1;
            ptr   <= cand_next;
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_XFER: begin
          if (tx_rdy) begin
            first <= 1'b0;
            // st must mark exactly the first accepted beat of the TLP
            if (first != cand_st) proto_err <= 1'b1;
            if (cand_end) begin
              gnt   <= '0;
              ptr   <= cand_next;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfif_tx_arb.sv
// Bench for sfif_tx_arb: requester queues plus a round-robin reference model, directed and random traffic.
module tb_sfif_tx_arb;
  localparam int N  = 2;
  localparam int TO = 1024;

  logic clk_125 = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic [N-1:0] req, req_np, req_st, req_end, req_dwen, req_rdy, gnt;
  logic [4*N-1:0] req_pd;
  logic [64*N-1:0] req_data;
  logic credit_available, tag_available, cp_ph, cp_nph, tx_rdy;
  logic tx64_st, tx64_end, tx64_dwen, tx_val, skip, proto_err;
  logic [3:0] cp_pd;
  logic [63:0] tx64_data;
  logic [2:0] sm;

  always #5 clk_125 = ~clk_125;

  sfif_tx_arb #(.N_REQ(N), .CR_TIMEOUT(TO)) dut (
    .clk_125(clk_125), .rstn(rstn), .enable(enable),
    .req(req), .req_np(req_np), .req_pd(req_pd), .req_st(req_st), .req_end(req_end),
    .req_dwen(req_dwen), .req_data(req_data), .req_rdy(req_rdy), .gnt(gnt),
    .credit_available(credit_available), .tag_available(tag_available),
    .cp_ph(cp_ph), .cp_nph(cp_nph), .cp_pd(cp_pd), .tx_rdy(tx_rdy),
    .tx64_st(tx64_st), .tx64_end(tx64_end), .tx64_dwen(tx64_dwen), .tx64_data(tx64_data),
    .tx_val(tx_val), .skip(skip), .proto_err(proto_err), .sm(sm)
  );

  int checks = 0;
  int errors = 0;

  int          len_q[N][$];
  logic [63:0] dat_q[N][$];
  int          bi[N];
  logic        np_r[N];
  logic [3:0]  pd_r[N];
  logic        dw_r[N];
  logic        bad_st[N];
  int          glog[$];
  logic        rdy_script[$];
  logic [N-1:0] acc, prev_gnt;
  int          rr_ptr, cur, tag_hold, wc, nskip, n;
  int unsigned rdy_pct;
  logic        cr_rand, exp_perr, prev_rdy;
  logic [63:0] last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending_total();
    int t = 0;
    for (int r = 0; r < N; r++) t += len_q[r].size();
    return t;
  endfunction

  // round robin: first requester with a queued TLP, searching cyclically from rr_ptr
  function automatic int first_pending();
    for (int k = 0; k < N; k++) begin
      if (len_q[(rr_ptr + k) % N].size() > 0) return (rr_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic load(input int r, input int len);
    len_q[r].push_back(len);
    for (int b = 0; b < len; b++) dat_q[r].push_back({$urandom, $urandom});
  endtask

  task automatic drive();
    req = '0; req_np = '0; req_st = '0; req_end = '0; req_dwen = '0; req_pd = '0; req_data = '0;
    for (int r = 0; r < N; r++) begin
      if (len_q[r].size() > 0) begin
        req[r]             = 1'b1;
        req_np[r]          = np_r[r];
        req_pd[4*r +: 4]   = pd_r[r];
        req_st[r]          = (bi[r] == 0) && !bad_st[r];
        req_end[r]         = (bi[r] == len_q[r][0] - 1);
        req_dwen[r]        = req_end[r] && dw_r[r];
        req_data[64*r +: 64] = dat_q[r][0];
      end
    end
  endtask

  task automatic advance();
    for (int r = 0; r < N; r++) begin
      if (acc[r] && len_q[r].size() > 0) begin
        if (bi[r] == 0 && bad_st[r]) exp_perr = 1'b1;
        void'(dat_q[r].pop_front());
        bi[r]++;
        if (bi[r] == len_q[r][0]) begin
          void'(len_q[r].pop_front());
          bi[r]  = 0;
          rr_ptr = (r + 1) % N;
        end
      end
    end
    acc = '0;
  endtask

  task automatic check_cycle();
    int e;
    nskip += int'(skip);
    if (skip) chk("skip_sm", 64'(sm), 64'(0));
    chk("perr", 64'(proto_err), 64'(exp_perr));
    if (gnt != '0) begin
      if (prev_gnt == '0) begin
        cur = first_pending();
        glog.push_back(cur);
        chk("gnt_rr", 64'(gnt), (cur < 0) ? 64'(0) : (64'(1) << cur));
      end else begin
        chk("gnt_hold", 64'(gnt), 64'(prev_gnt));
      end
      chk("sm_xfer", 64'(sm), 64'(3));
      chk("tx_val", 64'(tx_val), 64'(tx_rdy));
      if (cur >= 0) begin
        chk("req_rdy", 64'(req_rdy), tx_rdy ? (64'(1) << cur) : 64'(0));
        chk("pend", 64'(len_q[cur].size() > 0), 64'(1));
        if (len_q[cur].size() > 0) begin
          chk("data", tx64_data, dat_q[cur][0]);
          chk("flags", 64'({tx64_st, tx64_end, tx64_dwen}),
              64'({(bi[cur] == 0) && !bad_st[cur], bi[cur] == len_q[cur][0] - 1,
                   (bi[cur] == len_q[cur][0] - 1) && dw_r[cur]}));
        end
      end
      if (prev_gnt != '0 && !prev_rdy) chk("stall_hold", tx64_data, last_data);
      acc = req_rdy;
    end else begin
      chk("idle_out", 64'({tx_val, req_rdy, tx64_st, tx64_end, tx64_dwen}), 64'(0));
      chk("idle_data", tx64_data, 64'(0));
    end
    if (sm == 3'd1 || sm == 3'd2) begin
      e = first_pending();
      if (e >= 0) chk("probe", 64'({cp_ph, cp_nph, cp_pd}), 64'({!np_r[e], np_r[e], pd_r[e]}));
    end else begin
      chk("probe0", 64'({cp_ph, cp_nph, cp_pd}), 64'(0));
    end
    if (sm == 3'd2) wc++;
    prev_gnt  = gnt;
    prev_rdy  = tx_rdy;
    last_data = tx64_data;
  endtask

  task automatic tick();
    @(negedge clk_125);
    advance();
    if (prev_gnt != '0 && rdy_script.size() > 0) tx_rdy = rdy_script.pop_front();
    else tx_rdy = ($urandom_range(99, 0) < rdy_pct);
    if (cr_rand) credit_available = 1'($urandom_range(1, 0));
    tag_available = (tag_hold < 0) || (wc >= tag_hold);
    drive();
    #1;
    if (rstn) check_cycle();
  endtask

  task automatic run_done(input int maxc);
    int c = 0;
    while (pending_total() > 0 || gnt != '0) begin
      tick();
      c++;
      if (c >= maxc) begin
        chk("timeout_pending", 64'(pending_total()), 64'(0));
        break;
      end
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++) begin
      len_q[r].delete();
      dat_q[r].delete();
      bi[r] = 0;
    end
    acc = '0; prev_gnt = '0; prev_rdy = 1'b1; exp_perr = 1'b0; rr_ptr = 0; cur = 0;
  endtask

  initial begin
    credit_available = 1'b1; tag_available = 1'b1; tx_rdy = 1'b0;
    tag_hold = -1; rdy_pct = 100; cr_rand = 1'b0; wc = 0; nskip = 0; last_data = '0;
    for (int r = 0; r < N; r++) begin
      np_r[r] = 1'b0; pd_r[r] = 4'd2; dw_r[r] = 1'b0; bad_st[r] = 1'b0;
    end
    clear_model();
    drive();
    #2;
    chk("rst_ctl", 64'({gnt, req_rdy, cp_ph, cp_nph, cp_pd, tx64_st, tx64_end, tx64_dwen,
                       tx_val, skip, proto_err, sm}), 64'(0));
    chk("rst_data", tx64_data, 64'(0));
    repeat (2) @(negedge clk_125);
    rstn = 1'b1;

    // disabled arbiter must not grant
    load(0, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en_block", 64'({gnt, sm}), 64'(0));
    end

    // enable with credit ready: grant seen after the third edge, three beats, ptr moves to 1
    enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 20);
    chk("latency", 64'(n), 64'(3));
    chk("first_beat", 64'(tx_val), 64'(1));
    run_done(50);

    // both requesting: grants alternate starting from requester 1
    glog.delete();
    dw_r[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load(0, $urandom_range(4, 1));
      load(1, $urandom_range(4, 1));
    end
    run_done(200);
    chk("alt_n", 64'(glog.size()), 64'(4));
    for (int i = 0; i < glog.size() && i < 4; i++) chk("alt_order", 64'(glog[i]), 64'((1 + i) % 2));

    // non-posted, tag arrives on the last allowed wait cycle: no skip
    np_r[0] = 1'b1; tag_hold = TO - 1; wc = 0; nskip = 0;
    load(0, 2);
    run_done(TO + 50);
    chk("noskip", 64'(nskip), 64'(0));
    chk("wait_len_a", 64'(wc), 64'(TO));

    // tag one cycle too late: skip pulse, then re-arbitration succeeds
    tag_hold = TO; wc = 0; nskip = 0;
    load(0, 2);
    run_done(2 * TO + 50);
    chk("skip_n", 64'(nskip), 64'(1));
    chk("wait_len_b", 64'(wc), 64'(TO + 1));
    np_r[0] = 1'b0; tag_hold = -1;

    // stalls mid-TLP: data must hold while tx_rdy is low
    rdy_script = '{1'b1, 1'b0, 1'b0, 1'b1};
    load(1, 5);
    run_done(50);

    // requester 1 omits st on its first beat: sticky error, TLP still drains
    bad_st[1] = 1'b1;
    load(1, 3);
    run_done(50);
    chk("perr_set", 64'(proto_err), 64'(1));
    bad_st[1] = 1'b0;
    load(0, 2);
    run_done(50);
    chk("perr_sticky", 64'(proto_err), 64'(1));

    // asynchronous reset in the middle of a transfer
    load(0, 6);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 20);
    tick();
    @(negedge clk_125);
    rstn = 1'b0;
    #1;
    chk("rst_mid", 64'({gnt, tx_val, sm, req_rdy, proto_err, skip}), 64'(0));
    clear_model();
    tick();
    tick();
    chk("rst_hold", 64'({gnt, tx_val, sm}), 64'(0));
    rstn = 1'b1;

    // random traffic with random credit and back-pressure
    cr_rand = 1'b1; rdy_pct = 70;
    for (int r = 0; r < N; r++) begin
      np_r[r] = 1'($urandom_range(1, 0));
      pd_r[r] = 4'($urandom_range(15, 0));
      dw_r[r] = 1'($urandom_range(1, 0));
    end
    for (int i = 0; i < 30; i++) load($urandom_range(N - 1, 0), $urandom_range(4, 1));
    run_done(3000);
    chk("rand_drained", 64'(pending_total()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
